// File: rtl/act_unpacker.sv
// act_unpacker: streaming int8 activation unpacker for the KWS CFU input path.
// Takes one 32-bit word holding up to four packed int8 lanes and emits one
// 32-bit operand per cycle: (sign-extended lane + offset) << shift.
//
// State table:
//   state | meaning
//   IDLE  | no word held; ready to accept
//   EMIT  | word held; lane idx_q is presented on out_data
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     input word handshake
//   in_data, in_count     packed lanes (lane0 = [7:0]) and valid lane count
//   cfg_offset, cfg_shift per-word offset and left shift, sampled on accept
//   flush                 synchronous discard of the held word
//   out_valid/out_ready   output operand handshake
//   out_data, out_last    operand and final-lane marker
//   busy                  a word is held
module act_unpacker #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_count,
    input  logic [31:0] cfg_offset,
    input  logic [3:0]  cfg_shift,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [31:0] off_q, off_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  sh_q, sh_d;
    logic [1:0]  idx_q, idx_d;

    logic [7:0]  lane;
    logic [31:0] lane_sext;
    logic [31:0] sum;
    logic [2:0]  cnt_norm;
    logic        accept;
    logic        xfer;

    always_comb begin
        lane = word_q[7:0];
        case (idx_q)
            2'd0: lane = word_q[7:0];
            2'd1: lane = word_q[15:8];
            2'd2: lane = word_q[23:16];
            2'd3: lane = word_q[31:24];
            default: lane = word_q[7:0];
        endcase
    end

    // Output path is a function of registers only; the add wraps and the
    // shift drops bits above bit 31.
    assign lane_sext = {{24{lane[7]}}, lane};
    assign sum       = lane_sext + off_q;
    assign out_data  = sum << sh_q;

    assign out_valid = (state_q == EMIT);
    assign busy      = out_valid;
    assign out_last  = out_valid && ({1'b0, idx_q} == (cnt_q - 3'd1));

    assign xfer   = out_valid && out_ready;
    // out_ready feeds in_ready directly so a new word can load in the same
    // cycle the last lane leaves, giving bubble-free back-to-back words.
    assign in_ready = !reset && !flush && ((state_q == IDLE) || (xfer && out_last));
    assign accept   = in_valid && in_ready;

    assign cnt_norm = ((in_count == 3'd0) || (in_count > 3'(LANES))) ? 3'(LANES) : in_count;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = IDLE;
            idx_d   = 2'd0;
        end else begin
            if (xfer && !out_last) begin
                idx_d = idx_q + 2'd1;
            end else if (xfer && out_last) begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
            // A load on the final transfer overrides the return to IDLE.
            if (accept) begin
                word_d  = in_data;
                cnt_d   = cnt_norm;
                off_d   = cfg_offset;
                sh_d    = cfg_shift;
                idx_d   = 2'd0;
                state_d = EMIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= 32'd0;
            off_q   <= 32'd0;
            cnt_q   <= 3'd0;
            sh_q    <= 4'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_act_unpacker.sv
module tb_act_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_count;
    logic [31:0] cfg_offset;
    logic [3:0]  cfg_shift;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    act_unpacker #(.LANES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_count(in_count), .cfg_offset(cfg_offset), .cfg_shift(cfg_shift),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic [2:0]       cnt;
        logic [31:0]      off;
        logic [3:0]       sh;
        int               n;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t tbl [7];

    function automatic vec_t mkv(logic [31:0] d, logic [2:0] c, logic [31:0] o, logic [3:0] s,
                                 int n, logic [31:0] e0, logic [31:0] e1,
                                 logic [31:0] e2, logic [31:0] e3);
        vec_t v;
        v.data = d; v.cnt = c; v.off = o; v.sh = s; v.n = n;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // Reference operand: plain integer arithmetic, then keep the low 32 bits.
    function automatic logic [31:0] ref_op(logic [7:0] b, logic [31:0] off, logic [3:0] sh);
        longint v;
        v = longint'($signed(b)) + longint'($signed(off));
        v = v * (longint'(1) << sh);
        return 32'(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_word(vec_t v);
        @(negedge clk);
        in_data = v.data; in_count = v.cnt; cfg_offset = v.off; cfg_shift = v.sh;
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        #1 chk("idle_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_offset = $urandom; cfg_shift = 4'($urandom); in_data = $urandom;
        for (int k = 0; k < v.n; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("vec_valid", out_valid, 1);
            chk("vec_data", out_data, v.exp[k]);
            chk("vec_last", out_last, (k == v.n - 1) ? 1 : 0);
            chk("vec_in_ready", in_ready, (k == v.n - 1) ? 1 : 0);
        end
        @(negedge clk);
        #1 chk("vec_done_valid", out_valid, 0);
    endtask

    logic [31:0] q [$];
    logic [31:0] seq_exp [6];
    logic        seq_last [6];

    initial begin
        tbl[0] = mkv(32'h807FFF00, 3'd4, 32'd128, 4'd0, 4, 32'h80, 32'h7F, 32'hFF, 32'h0);
        tbl[1] = mkv(32'h000000FB, 3'd1, 32'hFFFFFFFD, 4'd4, 1, 32'hFFFFFF80, 0, 0, 0);
        tbl[2] = mkv(32'h000000FB, 3'd0, 32'hFFFFFFFD, 4'd4, 4,
                     32'hFFFFFF80, 32'hFFFFFFD0, 32'hFFFFFFD0, 32'hFFFFFFD0);
        tbl[3] = mkv(32'h00000201, 3'd2, 32'd0, 4'd0, 2, 32'd1, 32'd2, 0, 0);
        tbl[4] = mkv(32'h0000007F, 3'd1, 32'h7FFFFFFF, 4'd0, 1, 32'h8000007E, 0, 0, 0);
        tbl[5] = mkv(32'h04030201, 3'd7, 32'd0, 4'd1, 4, 32'd2, 32'd4, 32'd6, 32'd8);
        tbl[6] = mkv(32'h0000007F, 3'd1, 32'h00020000, 4'd15, 1, 32'h003F8000, 0, 0, 0);

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0;
        cfg_offset = '0; cfg_shift = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Table vectors.
        for (int i = 0; i < 7; i++) apply_word(tbl[i]);

        // Reset asserted mid-EMIT, between edges.
        @(negedge clk);
        in_data = 32'h04030201; in_count = 3'd4; cfg_offset = 0; cfg_shift = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("pre_async_valid", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back: word A then word B with no bubble.
        seq_exp  = '{32'h80, 32'h7F, 32'hFF, 32'h0, 32'd1, 32'd2};
        seq_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        in_data = 32'h807FFF00; in_count = 3'd4; cfg_offset = 32'd128; cfg_shift = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_data = 32'h00000201; in_count = 3'd2; cfg_offset = 0; cfg_shift = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) in_valid = 1'b0;
            #1;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", out_data, seq_exp[k]);
            chk("b2b_last", out_last, seq_last[k]);
        end
        @(negedge clk);
        #1 chk("b2b_done", out_valid, 0);

        // Backpressure at lane1, with config changes while held.
        @(negedge clk);
        in_data = 32'h04030201; in_count = 3'd4; cfg_offset = 0; cfg_shift = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("bp_lane0", out_data, 32'd1);
        @(negedge clk);
        out_ready = 1'b0; cfg_offset = 32'h55; cfg_shift = 4'd3;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("bp_hold_data", out_data, 32'd2);
            chk("bp_hold_last", out_last, 0);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("bp_resume1", out_data, 32'd2);
        @(negedge clk);
        #1 chk("bp_resume2", out_data, 32'd3);
        @(negedge clk);
        #1 chk("bp_resume3", out_data, 32'd4);
        chk("bp_resume3_last", out_last, 1);
        @(negedge clk);

        // Flush at lane2 with a competing word on the input.
        @(negedge clk);
        in_data = 32'h04030201; in_count = 3'd4; cfg_offset = 0; cfg_shift = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("fl_lane2", out_data, 32'd3);
        in_valid = 1'b1; flush = 1'b1;
        #1 chk("fl_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready_after", in_ready, 1);
        apply_word(tbl[5]);

        // Flush in IDLE leaves the block idle.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fl_idle_valid", out_valid, 0);

        // Randomised run against the queue model.
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic exp_ready;
            int   nl;
            @(negedge clk);
            in_valid   = ($urandom_range(0, 1) == 1);
            in_data    = $urandom;
            in_count   = 3'($urandom_range(0, 7));
            cfg_offset = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cfg_shift  = 4'($urandom_range(0, 15));
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 31) == 0);
            #1;
            exp_ready = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
            chk("rnd_valid", out_valid, (q.size() > 0) ? 1 : 0);
            chk("rnd_busy", busy, (q.size() > 0) ? 1 : 0);
            chk("rnd_in_ready", in_ready, exp_ready);
            if (q.size() > 0) begin
                chk("rnd_data", out_data, q[0]);
                chk("rnd_last", out_last, (q.size() == 1) ? 1 : 0);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && exp_ready) begin
                    nl = (in_count == 0 || in_count > 4) ? 4 : int'(in_count);
                    for (int l = 0; l < nl; l++)
                        q.push_back(ref_op(in_data[l*8 +: 8], cfg_offset, cfg_shift));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/act_unpacker.md
Name: act_unpacker

Overview:
- Streaming input-side converter for the KWS CFU datapath. It is the inverse of the output requantizer that produces offset int8 results.
- Accepts 32-bit words, each carrying up to four packed int8 activations, and emits one 32-bit operand per cycle.
- Each emitted operand is (sign-extended lane + offset) << shift.
- Sits between the CFU input command path and the MAC accumulator feed, with valid/ready handshakes on both sides.

Parameters:
- LANES, 4, int8 lanes per input word; the RTL supports only 4, and the parameter is for documentation/asserts.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  32  packed int8 lanes; lane0 = [7:0], lane1 = [15:8], lane2 = [23:16], lane3 = [31:24]
- in_count  in  3  number of valid lanes, starting at lane0; 1..4; 0 or >4 treated as 4
- cfg_offset  in  32  signed input offset, sampled with the word
- cfg_shift  in  4  left-shift amount 0..15, sampled with the word
- flush  in  1  synchronous; discards the held word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  32  unpacked, offset, shifted operand
- out_last  out  1  high with the final lane of the current word
- busy  out  1  a word is held (state EMIT)

Behaviour:
- Registers: word_q[31:0], cnt_q[2:0] (normalised to 1..4), off_q[31:0], sh_q[3:0], idx_q[1:0], state ∈ {IDLE, EMIT}.
- Reset (async, immediate, no clock needed):
  - state = IDLE; all data registers and idx_q = 0.
  - out_valid = 0, out_last = 0, busy = 0, out_data = 0.
  - in_ready = 0 while reset is asserted, 1 from the first cycle after deassertion.
- Output decode:
  - out_valid = (state == EMIT); busy = out_valid.
  - out_last = out_valid && (idx_q == cnt_q - 1).
  - out_data = (sext32(word_q lane idx_q) + off_q) << sh_q.
  - out_data is driven from registers only, so there is no combinational path from in_* to out_*.
- Arithmetic:
  - The 32-bit add wraps modulo 2^32; no saturation.
  - The shift is logical left; bits shifted past bit 31 are discarded.
- in_ready = !reset && (state == IDLE || (out_valid && out_ready && out_last)). The out_ready → in_ready combinational path is intentional.
- Accept = in_valid && in_ready. On accept:
  - Latch in_data, the normalised count, cfg_offset and cfg_shift.
  - idx_q = 0; state = EMIT.
  - Latency: word accepted at edge N gives lane0 on out_data with out_valid = 1 in cycle N+1.
- Transfer = out_valid && out_ready:
  - Not last: idx_q++.
  - Last, with no simultaneous accept: state = IDLE, idx_q = 0.
  - Last with a simultaneous accept: reload and stay in EMIT. There is no bubble, so sustained throughput is 1 operand/cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_last and idx_q hold stable.
- Config: cfg_* changes after accept have no effect on the held word.
- flush:
  - Next edge forces state = IDLE, idx_q = 0; the held word is dropped.
  - in_ready during the flush cycle is forced to 0, so no accept occurs.
  - flush overrides a simultaneous transfer or accept.
  - flush in IDLE has no effect.

Test Plan:
1. Reset and idle:
   - Hold reset 3 cycles → out_valid = 0, in_ready = 0, out_data = 0.
   - Release → in_ready = 1 next cycle.
   - Assert reset mid-EMIT between edges → out_valid drops without a clock edge.
2. Basic unpack:
   - Stimulus: in_data = 0x807FFF00, in_count = 4, offset = 128, shift = 0, out_ready = 1.
   - Expected: outputs 128, 127, 255, 0 on consecutive cycles, first output one cycle after accept.
   - out_last is high only on the 4th output; in_ready is high in that same cycle.
3. Offset/shift and count handling:
   - Stimulus: in_data = 0x000000FB (lane0 = -5), offset = -3, shift = 4, count = 1.
   - Expected: single output 0xFFFFFF80 (-128) with out_last = 1.
   - Repeat with count = 0 → 4 outputs.
4. Back-to-back with partial word:
   - Stimulus: word A (count 4), then word B = 0x00000201 (count 2, offset 0, shift 0) presented continuously, out_ready = 1.
   - Expected: 6 consecutive out_valid cycles with no bubble; last two outputs are 1 and 2; out_last on outputs 4 and 6.
5. Backpressure:
   - Stimulus: drop out_ready for 3 cycles at lane1.
   - Expected: out_data and out_last stable; in_ready = 0; lane sequence resumes unchanged.
6. Flush and wrap:
   - Stimulus: flush at lane2.
   - Expected: next cycle out_valid = 0, in_ready = 1; the next word starts at lane0.
   - Wrap check: lane 0x7F, offset 0x7FFFFFFF, shift 0 → out_data = 0x8000007E.
